// File: rtl/piton_vortex_launch_seq_if.sv
// Launch sequencer bus: core-ctrl handshakes plus the Vortex DCR/reset/busy side.
// master drives the sequencer inputs, slave is the sequencer itself.
`timescale 1ns/1ps
interface piton_vortex_launch_seq_if #(
    parameter int DCR_ADDR_WIDTH = 12,
    parameter int DCR_DATA_WIDTH = 32
);
    logic                      cfg_val;
    logic [DCR_ADDR_WIDTH-1:0] cfg_addr;
    logic [DCR_DATA_WIDTH-1:0] cfg_data;
    logic                      cfg_rdy;
    logic                      launch_val;
    logic                      launch_rdy;
    logic                      abort;
    logic                      dcr_wr_valid;
    logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr;
    logic [DCR_DATA_WIDTH-1:0] dcr_wr_data;
    logic                      vortex_reset;
    logic                      vortex_busy;
    logic                      done_val;
    logic [1:0]                done_status;
    logic                      done_rdy;
    logic [31:0]               run_cycles;
    logic [2:0]                seq_state;

    modport master (
        output cfg_val, cfg_addr, cfg_data, launch_val, abort,
        output vortex_busy, done_rdy,
        input  cfg_rdy, launch_rdy, dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
        input  vortex_reset, done_val, done_status, run_cycles, seq_state
    );

    modport slave (
        input  cfg_val, cfg_addr, cfg_data, launch_val, abort,
        input  vortex_busy, done_rdy,
        output cfg_rdy, launch_rdy, dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
        output vortex_reset, done_val, done_status, run_cycles, seq_state
    );
endinterface

// File: rtl/piton_vortex_launch_seq.sv
// Vortex launch sequencer: buffers DCR writes, replays them under reset, tracks the run.
// Optional run-cycle counter: define PITON_VORTEX_LAUNCH_SEQ_CYCLE_CNT_EN.
`timescale 1ns/1ps
module piton_vortex_launch_seq #(
    parameter int DCR_ADDR_WIDTH = 12,
    parameter int DCR_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int RST_CYCLES     = 16,
    parameter int START_TIMEOUT  = 1024
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    piton_vortex_launch_seq_if.slave bus
);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int EW      = DCR_ADDR_WIDTH + DCR_DATA_WIDTH;
    localparam int CNT_MAX = (RST_CYCLES > START_TIMEOUT) ? RST_CYCLES : START_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [PW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_HOLD  = 3'd2,
        S_WAIT  = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic [PW:0]               wptr_q, wptr_d, rptr_q, rptr_d;
    logic [EW-1:0]             mem_q [FIFO_DEPTH];
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      dcr_valid_q, dcr_valid_d;
    logic [DCR_ADDR_WIDTH-1:0] dcr_addr_q, dcr_addr_d;
    logic [DCR_DATA_WIDTH-1:0] dcr_data_q, dcr_data_d;
    logic                      vrst_q, vrst_d;
    logic                      done_val_q, done_val_d;
    logic [1:0]                status_q, status_d;

    logic          fifo_empty, fifo_full;
    logic          push, launch, pop, avail;
    logic [EW-1:0] head;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) &&
                        (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

    assign bus.cfg_rdy    = (state_q == S_IDLE) && !fifo_full;
    assign bus.launch_rdy = (state_q == S_IDLE);

    assign push   = bus.cfg_val & bus.cfg_rdy;
    assign launch = bus.launch_val & bus.launch_rdy;
    assign avail  = !fifo_empty || push;
    // A cfg write arriving with the launch into an empty FIFO is forwarded directly.
    assign head   = fifo_empty ? {bus.cfg_addr, bus.cfg_data}
                               : mem_q[rptr_q[PW-1:0]];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vrst_d      = vrst_q;
        done_val_d  = done_val_q;
        status_d    = status_q;
        wptr_d      = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d      = rptr_q;
        pop         = 1'b0;
        dcr_valid_d = 1'b0;
        dcr_addr_d  = dcr_addr_q;
        dcr_data_d  = dcr_data_q;

        unique case (state_q)
            S_IDLE: begin
                vrst_d = 1'b1;
                if (launch) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    vrst_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT: begin
                if (bus.vortex_busy) begin
                    state_d = S_RUN;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    state_d    = S_DONE;
                    status_d   = 2'b10;
                    done_val_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RUN: begin
                if (!bus.vortex_busy) begin
                    state_d    = S_DONE;
                    status_d   = 2'b00;
                    done_val_d = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.done_rdy) begin
                    state_d    = S_IDLE;
                    done_val_d = 1'b0;
                    vrst_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.abort && (state_q inside {S_DRAIN, S_HOLD, S_WAIT, S_RUN})) begin
            state_d    = S_DONE;
            status_d   = 2'b01;
            done_val_d = 1'b1;
            vrst_d     = 1'b1;
            rptr_d     = wptr_q;
        end

        // Pop one cycle ahead so the registered strobe lines up with DRAIN.
        pop = (state_d == S_DRAIN) && avail;
        if (pop) begin
            rptr_d      = rptr_q + PTR_ONE;
            dcr_valid_d = 1'b1;
            dcr_addr_d  = head[EW-1:DCR_DATA_WIDTH];
            dcr_data_d  = head[DCR_DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wptr_q[PW-1:0]] <= {bus.cfg_addr, bus.cfg_data};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            dcr_valid_q <= 1'b0;
            dcr_addr_q  <= '0;
            dcr_data_q  <= '0;
            vrst_q      <= 1'b1;
            done_val_q  <= 1'b0;
            status_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            dcr_valid_q <= dcr_valid_d;
            dcr_addr_q  <= dcr_addr_d;
            dcr_data_q  <= dcr_data_d;
            vrst_q      <= vrst_d;
            done_val_q  <= done_val_d;
            status_q    <= status_d;
        end
    end

`ifdef PITON_VORTEX_LAUNCH_SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d, run_q, run_d;

    always_comb begin
        cyc_d = cyc_q;
        run_d = run_q;
        if (state_q == S_HOLD && state_d != S_HOLD) begin
            cyc_d = '0;
        end else if ((state_q == S_WAIT || state_q == S_RUN) && cyc_q != '1) begin
            cyc_d = cyc_q + 32'd1;
        end
        if (state_d == S_DONE && state_q != S_DONE) run_d = cyc_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cyc_q <= '0;
            run_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            run_q <= run_d;
        end
    end

    assign bus.run_cycles = run_q;
`else
    assign bus.run_cycles = '0;
`endif

    assign bus.dcr_wr_valid = dcr_valid_q;
    assign bus.dcr_wr_addr  = dcr_addr_q;
    assign bus.dcr_wr_data  = dcr_data_q;
    assign bus.vortex_reset = vrst_q;
    assign bus.done_val     = done_val_q;
    assign bus.done_status  = status_q;
    assign bus.seq_state    = state_q;
endmodule

// File: tb/tb_piton_vortex_launch_seq.sv
// Bench for piton_vortex_launch_seq: directed + randomized launches against a
// timing/queue model derived from the sequencing rules.
`timescale 1ns/1ps
module tb_piton_vortex_launch_seq;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int RSTC  = 16;
    localparam int STO   = 1024;
    localparam int EW    = AW + DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    piton_vortex_launch_seq_if #(.DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW)) bus();

    piton_vortex_launch_seq #(
        .DCR_ADDR_WIDTH(AW), .DCR_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
        .RST_CYCLES(RSTC), .START_TIMEOUT(STO)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .bus(bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [EW-1:0] mq[$];
    logic [EW-1:0] sq[$];
    int            scq[$];
    int            hold_cyc = -1;
    int            fall_cyc = -1;
    logic          prev_rst = 1'b1;
    logic [2:0]    prev_st = 3'd0;

    always @(negedge clk) begin
        if (bus.dcr_wr_valid) begin
            sq.push_back({bus.dcr_wr_addr, bus.dcr_wr_data});
            scq.push_back(cyc);
        end
        if (bus.seq_state == 3'd2 && prev_st != 3'd2) hold_cyc = cyc;
        if (!bus.vortex_reset && prev_rst) fall_cyc = cyc;
        prev_st  = bus.seq_state;
        prev_rst = bus.vortex_reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_cfg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc;
        acc = (mq.size() < DEPTH);
        bus.cfg_val  = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        chk("cfg_rdy", {63'd0, bus.cfg_rdy}, {63'd0, acc});
        if (acc) mq.push_back({a, d});
        tick();
        bus.cfg_val = 1'b0;
    endtask

    task automatic put_rand(input int n);
        for (int i = 0; i < n; i++) put_cfg(AW'($urandom), $urandom);
    endtask

    task automatic handshake(input int rdy_wait, input logic [1:0] st_exp, input string tag);
        bit stable;
        stable = 1'b1;
        bus.done_rdy = 1'b0;
        for (int i = 0; i < rdy_wait; i++) begin
            tick();
            if (bus.done_val !== 1'b1 || bus.done_status !== st_exp ||
                bus.launch_rdy !== 1'b0) stable = 1'b0;
        end
        chk({tag, " done_stable"}, {63'd0, stable}, 64'd1);
        bus.done_rdy = 1'b1;
        tick();
        bus.done_rdy = 1'b0;
        chk({tag, " idle_after_rdy"}, bus.seq_state, 3'd0);
        chk({tag, " vrst_after_rdy"}, bus.vortex_reset, 1'b1);
    endtask

    // busy_off: cycles after WAIT_BUSY entry that busy rises (<0: never).
    task automatic launch_run(input int busy_off, input int busy_len,
                              input int rdy_wait, input bit cfg_too, input string tag);
        int T, n, w, b0, b1, done_exp, run_exp;
        logic [1:0] st_exp;
        bit timeout;
        sq.delete();
        scq.delete();
        hold_cyc = -1;
        fall_cyc = -1;
        T = cyc;
        if (cfg_too) begin
            bus.cfg_val  = 1'b1;
            bus.cfg_addr = AW'($urandom);
            bus.cfg_data = $urandom;
            chk({tag, " cfg_rdy_at_launch"}, {63'd0, bus.cfg_rdy},
                {63'd0, mq.size() < DEPTH});
            if (mq.size() < DEPTH) mq.push_back({bus.cfg_addr, bus.cfg_data});
        end
        bus.launch_val = 1'b1;
        chk({tag, " launch_rdy"}, bus.launch_rdy, 1'b1);
        tick();
        bus.launch_val = 1'b0;
        bus.cfg_val    = 1'b0;
        n = mq.size();
        w = T + ((n > 1) ? n : 1) + RSTC + 1;
        b0 = w + busy_off;
        b1 = b0 + busy_len;
        if (busy_off < 0) begin
            done_exp = w + STO;
            st_exp   = 2'b10;
            run_exp  = STO - 1;
        end else begin
            done_exp = b1 + 1;
            st_exp   = 2'b00;
            run_exp  = b1 - w;
        end
`ifndef PITON_VORTEX_LAUNCH_SEQ_CYCLE_CNT_EN
        run_exp = 0;
`endif
        timeout = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            bus.vortex_busy = (busy_off >= 0) && (cyc >= b0) && (cyc < b1);
            if (bus.done_val) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        bus.vortex_busy = 1'b0;
        chk({tag, " done_timeout"}, {63'd0, timeout}, 64'd0);
        chk({tag, " done_cycle"}, cyc, done_exp);
        chk({tag, " status"}, bus.done_status, st_exp);
        chk({tag, " run_cycles"}, bus.run_cycles, run_exp);
        chk({tag, " vrst_in_done"}, bus.vortex_reset, 1'b0);
        chk({tag, " hold_cycle"}, hold_cyc, T + ((n > 1) ? n : 1) + 1);
        chk({tag, " rst_fall_cycle"}, fall_cyc, w);
        chk({tag, " strobe_count"}, sq.size(), n);
        for (int i = 0; i < n && i < sq.size(); i++) begin
            chk({tag, " strobe_data"}, sq[i], mq[i]);
            chk({tag, " strobe_cycle"}, scq[i], T + 1 + i);
        end
        mq.delete();
        handshake(rdy_wait, st_exp, tag);
    endtask

    initial begin
        bit timeout;
        logic [EW-1:0] ninth;
        int T;
        bus.cfg_val = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.launch_val = 1'b0;
        bus.abort = 1'b0;
        bus.vortex_busy = 1'b0;
        bus.done_rdy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst state", bus.seq_state, 3'd0);
        chk("rst vrst", bus.vortex_reset, 1'b1);
        chk("rst dcr_valid", bus.dcr_wr_valid, 1'b0);
        chk("rst dcr_addr", bus.dcr_wr_addr, 12'h0);
        chk("rst dcr_data", bus.dcr_wr_data, 32'h0);
        chk("rst done_val", bus.done_val, 1'b0);
        chk("rst status", bus.done_status, 2'b00);
        chk("rst run_cycles", bus.run_cycles, 32'd0);
        chk("rst cfg_rdy", bus.cfg_rdy, 1'b1);

        put_cfg(12'h001, 32'hA);
        put_cfg(12'h002, 32'hB);
        put_cfg(12'h003, 32'hC);
        launch_run(5, 100, 20, 1'b0, "basic3");

        put_rand(8);
        ninth = {AW'($urandom), 32'($urandom)};
        put_cfg(ninth[EW-1:DW], ninth[DW-1:0]);
        launch_run(3, 10, 0, 1'b0, "full8");
        put_cfg(ninth[EW-1:DW], ninth[DW-1:0]);
        launch_run(0, 5, 1, 1'b0, "ninth");

        launch_run(-1, 0, 20, 1'b0, "timeout");

        for (int r = 0; r < 5; r++) begin
            put_rand($urandom_range(0, 8));
            launch_run($urandom_range(0, 20), $urandom_range(1, 40),
                       $urandom_range(0, 4), 1'($urandom_range(0, 1)), "rand");
        end

        put_rand(5);
        sq.delete();
        bus.launch_val = 1'b1;
        tick();
        bus.launch_val = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_drain state", bus.seq_state, 3'd5);
        chk("abort_drain status", bus.done_status, 2'b01);
        chk("abort_drain vrst", bus.vortex_reset, 1'b1);
        handshake(0, 2'b01, "abort_drain");
        tick();
        chk("abort_drain strobes", sq.size(), 2);
        if (sq.size() == 2) begin
            chk("abort_drain s0", sq[0], mq[0]);
            chk("abort_drain s1", sq[1], mq[1]);
        end
        mq.delete();
        launch_run(2, 8, 0, 1'b0, "after_flush");

        bus.launch_val = 1'b1;
        bus.vortex_busy = 1'b1;
        tick();
        bus.launch_val = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.seq_state == 3'd4) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        chk("abort_run reach_run", {63'd0, timeout}, 64'd0);
        for (int i = 0; i < 9; i++) tick();
        chk("abort_run vrst_before", bus.vortex_reset, 1'b0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.vortex_busy = 1'b0;
        chk("abort_run vrst", bus.vortex_reset, 1'b1);
        chk("abort_run state", bus.seq_state, 3'd5);
        chk("abort_run status", bus.done_status, 2'b01);
        handshake(3, 2'b01, "abort_run");
        put_rand(2);
        launch_run(4, 12, 0, 1'b0, "after_abort");

        bus.launch_val = 1'b1;
        bus.vortex_busy = 1'b1;
        tick();
        bus.launch_val = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (bus.seq_state == 3'd4) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        chk("arst reach_run", {63'd0, timeout}, 64'd0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst vrst", bus.vortex_reset, 1'b1);
        chk("arst done_val", bus.done_val, 1'b0);
        chk("arst state", bus.seq_state, 3'd0);
        bus.vortex_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        put_rand(3);
        #2 rst_n = 1'b0;
        mq.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst fifo cfg_rdy", bus.cfg_rdy, 1'b1);
        launch_run(1, 6, 0, 1'b0, "after_arst");

        T = cyc;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
